// File: rtl/hdmi_island_scheduler.sv
// rtl/hdmi_island_scheduler.sv - HDMI data island period sequencer with round-robin packet slots
// Optional feature macro: HDMI_SCHED_AUDIO_PRIORITY_EN (req[0] wins every arbitration it is in).
module hdmi_island_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int BIT_WIDTH    = 10,
  parameter int ISLAND_OPEN  = 10,
  parameter int ISLAND_CLOSE = 130,
  parameter int MAX_PACKETS  = 18
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [2:0]           packet_index,
  output logic [1:0]           mode,
  output logic [4:0]           packet_pixel_counter
);

  generate
    if (ISLAND_CLOSE - ISLAND_OPEN < 45) begin : g_bad_window
      $error("hdmi_island_scheduler: island window too short");
    end
    if (MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_bad_max_packets
      $error("hdmi_island_scheduler: MAX_PACKETS must be 1..18");
    end
    if (NUM_REQ > 7) begin : g_bad_num_req
      $error("hdmi_island_scheduler: NUM_REQ must be <= 7");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_LEAD_GUARD, S_PACKET, S_TRAIL_GUARD
  } state_t;

  state_t             state, state_d;
  logic [4:0]         cnt, cnt_d;
  logic [4:0]         pkt_cnt, pkt_cnt_d;
  logic [2:0]         ptr, ptr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [2:0]         packet_index_d;
  logic [1:0]         mode_d;
  logic [4:0]         ppc_d;
  logic               decide, cont, pkt_start, win_valid;
  logic [2:0]         win_idx;
  int                 best_off, off;

  // Round-robin search: the requester with the smallest distance past the pointer wins.
  always_comb begin
    best_off = NUM_REQ;
    off      = 0;
    win_idx  = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      off = (k + 2 * NUM_REQ - int'(ptr) - 1) % NUM_REQ;
      if (req[k] && off < best_off) begin
        best_off = off;
        win_idx  = 3'(k);
      end
    end
    win_valid = (best_off < NUM_REQ);
`ifdef HDMI_SCHED_AUDIO_PRIORITY_EN
    if (req[0]) begin
      win_idx = 3'd0;
    end
`endif
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      pkt_cnt              <= '0;
      ptr                  <= 3'(NUM_REQ - 1);
      grant                <= '0;
      packet_index         <= '0;
      mode                 <= '0;
      packet_pixel_counter <= '0;
    end else begin
      state                <= state_d;
      cnt                  <= cnt_d;
      pkt_cnt              <= pkt_cnt_d;
      ptr                  <= ptr_d;
      grant                <= grant_d;
      packet_index         <= packet_index_d;
      mode                 <= mode_d;
      packet_pixel_counter <= ppc_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 5'd1;
    pkt_cnt_d = pkt_cnt;
    ptr_d     = ptr;
    decide    = (state == S_LEAD_GUARD && cnt == 5'd1) || (state == S_PACKET && cnt == 5'd31);
    // Another packet must still leave room for itself plus the trailing guard.
    cont      = (pkt_cnt < 5'(MAX_PACKETS)) && (|req) && (int'(cx) + 34 <= ISLAND_CLOSE - 1);
    case (state)
      S_IDLE: begin
        cnt_d     = '0;
        pkt_cnt_d = '0;
        if (cx == BIT_WIDTH'(ISLAND_OPEN) && (|req)) begin
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (cnt == 5'd7) begin
          state_d = S_LEAD_GUARD;
          cnt_d   = '0;
        end
      end
      S_LEAD_GUARD: begin
        if (cnt == 5'd1) begin
          state_d = S_PACKET;
          cnt_d   = '0;
        end
      end
      S_PACKET: begin
        if (cnt == 5'd31) begin
          state_d = cont ? S_PACKET : S_TRAIL_GUARD;
          cnt_d   = '0;
        end
      end
      S_TRAIL_GUARD: begin
        if (cnt == 5'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    pkt_start = decide && (state_d == S_PACKET);
    if (pkt_start) begin
      pkt_cnt_d = pkt_cnt + 5'd1;
`ifdef HDMI_SCHED_AUDIO_PRIORITY_EN
      if (win_valid && win_idx != 3'd0) begin
        ptr_d = win_idx;
      end
`else
      if (win_valid) begin
        ptr_d = win_idx;
      end
`endif
    end
  end

  always_comb begin
    mode_d         = 2'd0;
    ppc_d          = '0;
    grant_d        = '0;
    packet_index_d = packet_index;
    case (state_d)
      S_PREAMBLE:                  mode_d = 2'd1;
      S_LEAD_GUARD, S_TRAIL_GUARD: mode_d = 2'd2;
      S_PACKET: begin
        mode_d = 2'd3;
        ppc_d  = cnt_d;
      end
      default:                     mode_d = 2'd0;
    endcase
    // An empty request set at the first slot yields a null packet tagged NUM_REQ.
    if (pkt_start) begin
      packet_index_d = win_valid ? win_idx : 3'(NUM_REQ);
      if (win_valid) begin
        grant_d = NUM_REQ'(1) << win_idx;
      end
    end
  end

endmodule
